// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle MIPS-subset core with req/ready memory ports
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata instruction fetch port (byte address relative to TEXT_BASE)
//   dmem_req/we/addr/wdata/ready/rdata  data port (byte address relative to DATA_BASE)
//   pc                        architectural PC of the current instruction
//   halted                    sticky fault flag (illegal opcode/funct, misaligned lw/sw)
//   dbg_sel, dbg_out          combinational register-file debug read
//   perf_cycles, perf_retired performance counters, built only with CPU_MC_PERF_EN
//
// Optional feature macro: CPU_MC_PERF_EN

module cpu_multicycle #(
   parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
   parameter logic [31:0] DATA_BASE  = 32'h1000_0000,
   parameter int          ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [31:0]           imem_rdata,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [31:0]           dmem_rdata,
   output logic [31:0]           pc,
   output logic                  halted,
   input  logic [4:0]            dbg_sel,
   output logic [31:0]           dbg_out,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_retired
);

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] ir;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] res;
   logic [31:0] regs [32];

   // Instruction fields, taken from the latched IR
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;

   assign op     = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign funct  = ir[5:0];
   assign imm    = ir[15:0];
   assign target = ir[25:0];

   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] jump_target;

   assign imm_sext    = {{16{imm[15]}}, imm};
   assign imm_zext    = {16'h0000, imm};
   assign pc_plus4    = pc + 32'd4;
   assign br_target   = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign jump_target = {pc[31:28], target, 2'b00};

   logic       is_rtype;
   logic       legal;
   logic       is_j;
   logic       is_jal;
   logic       is_beq;
   logic       is_bne;
   logic       is_jr;
   logic       is_lw;
   logic       is_sw;
   logic       br_taken;
   logic [4:0] wb_addr;

   always_comb begin
      is_rtype = (op == OP_R);
      is_j     = (op == OP_J);
      is_jal   = (op == OP_JAL);
      is_beq   = (op == OP_BEQ);
      is_bne   = (op == OP_BNE);
      is_jr    = is_rtype && (funct == F_JR);
      is_lw    = (op == OP_LW);
      is_sw    = (op == OP_SW);
      br_taken = is_beq ? (a_reg == b_reg) : (a_reg != b_reg);
      wb_addr  = is_rtype ? rd : rt;
      legal    = 1'b0;
      case (op)
         OP_R: begin
            case (funct)
               F_SLL, F_SRL, F_SRA, F_JR,
               F_ADD, F_ADDU, F_SUB, F_SUBU,
               F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU: legal = 1'b1;
               default:       legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_BEQ, OP_BNE,
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
         OP_LW, OP_SW: legal = 1'b1;
         default:      legal = 1'b0;
      endcase
   end

   // ALU; lw/sw reuse the addi path to form the effective address
   logic [31:0] alu_res;

   always_comb begin
      alu_res = 32'h0;
      case (op)
         OP_R: begin
            case (funct)
               F_SLL:          alu_res = b_reg << shamt;
               F_SRL:          alu_res = b_reg >> shamt;
               F_SRA:          alu_res = $signed(b_reg) >>> shamt;
               F_ADD, F_ADDU:  alu_res = a_reg + b_reg;
               F_SUB, F_SUBU:  alu_res = a_reg - b_reg;
               F_AND:          alu_res = a_reg & b_reg;
               F_OR:           alu_res = a_reg | b_reg;
               F_XOR:          alu_res = a_reg ^ b_reg;
               F_NOR:          alu_res = ~(a_reg | b_reg);
               F_SLT:          alu_res = {31'b0, $signed(a_reg) < $signed(b_reg)};
               F_SLTU:         alu_res = {31'b0, a_reg < b_reg};
               default:        alu_res = 32'h0;
            endcase
         end
         OP_ADDI, OP_ADDIU,
         OP_LW, OP_SW:  alu_res = a_reg + imm_sext;
         OP_SLTI:       alu_res = {31'b0, $signed(a_reg) < $signed(imm_sext)};
         OP_SLTIU:      alu_res = {31'b0, a_reg < imm_sext};
         OP_ANDI:       alu_res = a_reg & imm_zext;
         OP_ORI:        alu_res = a_reg | imm_zext;
         OP_XORI:       alu_res = a_reg ^ imm_zext;
         OP_LUI:        alu_res = {imm, 16'h0000};
         default:       alu_res = 32'h0;
      endcase
   end

   // pc only moves on state changes, so the fetch address is stable while requested
   assign imem_addr  = pc[ADDR_WIDTH-1:0] - TEXT_BASE[ADDR_WIDTH-1:0];
   assign dmem_wdata = b_reg;
   assign dbg_out    = regs[dbg_sel];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_FETCH;
         pc        <= TEXT_BASE;
         ir        <= 32'h0;
         a_reg     <= 32'h0;
         b_reg     <= 32'h0;
         res       <= 32'h0;
         imem_req  <= 1'b0;
         dmem_req  <= 1'b0;
         dmem_we   <= 1'b0;
         dmem_addr <= '0;
         halted    <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'h0;
         end
      end else begin
         case (state)
            S_FETCH: begin
               // Out of reset the request is raised on the first edge;
               // every later entry into FETCH raises it on the way in.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ready) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_reg <= regs[rs];
               b_reg <= regs[rt];
               if (!legal) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (is_j || is_jal) begin
                  if (is_jal) begin
                     regs[31] <= pc_plus4;
                  end
                  pc       <= jump_target;
                  imem_req <= 1'b1;
                  state    <= S_FETCH;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               res <= alu_res;
               if (is_beq || is_bne) begin
                  pc       <= br_taken ? br_target : pc_plus4;
                  imem_req <= 1'b1;
                  state    <= S_FETCH;
               end else if (is_jr) begin
                  pc       <= a_reg;
                  imem_req <= 1'b1;
                  state    <= S_FETCH;
               end else if (is_lw || is_sw) begin
                  if (alu_res[1:0] != 2'b00) begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end else begin
                     dmem_req  <= 1'b1;
                     dmem_we   <= is_sw;
                     dmem_addr <= alu_res[ADDR_WIDTH-1:0] - DATA_BASE[ADDR_WIDTH-1:0];
                     state     <= S_MEM;
                  end
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (dmem_we) begin
                     pc       <= pc_plus4;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     res   <= dmem_rdata;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_addr != 5'd0) begin
                  regs[wb_addr] <= res;
               end
               pc       <= pc_plus4;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

`ifdef CPU_MC_PERF_EN
   logic [31:0] cycles_q;
   logic [31:0] retired_q;
   logic        retire;

   // An instruction completes on the edge that takes it back to FETCH
   always_comb begin
      retire = 1'b0;
      case (state)
         S_DECODE: retire = legal && (is_j || is_jal);
         S_EXEC:   retire = is_beq || is_bne || is_jr;
         S_MEM:    retire = dmem_ready && dmem_we;
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycles_q  <= 32'h0;
         retired_q <= 32'h0;
      end else begin
         if (state != S_HALT) begin
            cycles_q <= cycles_q + 32'd1;
         end
         if (retire) begin
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   assign perf_cycles  = cycles_q;
   assign perf_retired = retired_q;
`else
   assign perf_cycles  = 32'h0;
   assign perf_retired = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - directed self-checking bench for cpu_multicycle

module tb_cpu_multicycle;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] pc;
   logic        halted;
   logic [4:0]  dbg_sel;
   logic [31:0] dbg_out;
   logic [31:0] perf_cycles;
   logic [31:0] perf_retired;

   logic [31:0] imem [0:1023];
   logic [31:0] dmem [0:255];

   int cyc     = 0;
   int fetches = 0;
   int dreqs   = 0;
   int checks  = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   cpu_multicycle dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .pc           (pc),
      .halted       (halted),
      .dbg_sel      (dbg_sel),
      .dbg_out      (dbg_out),
      .perf_cycles  (perf_cycles),
      .perf_retired (perf_retired)
   );

   assign imem_rdata = imem[imem_addr[11:2]];
   assign dmem_rdata = dmem[dmem_addr[9:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (imem_req && imem_ready) fetches <= fetches + 1;
      if (dmem_req) dreqs <= dreqs + 1;
      if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_pc(input string tag, input logic [31:0] target, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pc === target) begin
            at_cyc = cyc;
            break;
         end
      end
      check(tag, pc, target);
   endtask

   task automatic wait_halt(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (halted === 1'b1) break;
      end
      check(tag, {31'b0, halted}, 32'h1);
   endtask

   task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
      dbg_sel = r;
      #1;
      check(tag, dbg_out, exp);
   endtask

   int t0, t1, t2, t3, t4, t5, f0, d0;

   initial begin
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      dbg_sel    = 5'd0;
      for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
      imem[0]    = 32'h24010005;   // addiu $1,$0,5
      imem[1]    = 32'h2422FFF9;   // addiu $2,$1,-7
      imem[2]    = 32'h00221823;   // subu  $3,$1,$2
      imem[3]    = 32'h3C1C1000;   // lui   $28,0x1000
      imem[4]    = 32'hAF810004;   // sw    $1,4($28)
      imem[5]    = 32'h8F840004;   // lw    $4,4($28)
      imem[6]    = 32'h14210005;   // bne   $1,$1,+5 (not taken)
      imem[7]    = 32'h0C100040;   // jal   0x00400100
      imem[8]    = 32'h1021FFFF;   // beq   $1,$1,-1 (self loop)
      imem[64]   = 32'h03E00008;   // jr    $31

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pc", pc, 32'h00400000);
      check("rst_imem_req", {31'b0, imem_req}, 32'h0);
      check("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_perf_retired", perf_retired, 32'h0);

      // First cycle after release issues the fetch of TEXT_BASE
      rst = 1'b1;
      @(negedge clk);
      check("first_imem_req", {31'b0, imem_req}, 32'h1);
      check("first_imem_addr", {16'h0, imem_addr}, 32'h0);
      check("first_pc", pc, 32'h00400000);

      // Three ALU instructions at 4 cycles each
      repeat (12) @(negedge clk);
      read_reg("alu_r3", 5'd3, 32'h00000007);
      read_reg("alu_r2", 5'd2, 32'hFFFFFFFE);
      read_reg("alu_r1", 5'd1, 32'h00000005);
`ifdef CPU_MC_PERF_EN
      check("perf_retired_3", perf_retired, 32'd3);
`else
      check("perf_retired_off", perf_retired, 32'd0);
`endif

      // sw with three wait cycles on the data port
      wait_pc("pc_sw", 32'h00400010, t0);
      for (int i = 0; i < 20; i++) begin
         if (dmem_req === 1'b1) break;
         @(negedge clk);
      end
      check("sw_req", {31'b0, dmem_req}, 32'h1);
      check("sw_we", {31'b0, dmem_we}, 32'h1);
      check("sw_addr", {16'h0, dmem_addr}, 32'h4);
      check("sw_wdata", dmem_wdata, 32'h5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sw_hold_req", {31'b0, dmem_req}, 32'h1);
         check("sw_hold_addr", {16'h0, dmem_addr}, 32'h4);
         check("sw_hold_wdata", dmem_wdata, 32'h5);
      end
      dmem_ready = 1'b1;
      wait_pc("pc_lw", 32'h00400014, t1);
      check("sw_cycles", t1 - t0, 32'd7);
      check("sw_mem", dmem[1], 32'h5);

      wait_pc("pc_bne", 32'h00400018, t2);
      check("lw_cycles", t2 - t1, 32'd5);
      read_reg("lw_r4", 5'd4, 32'h00000005);

      wait_pc("pc_jal", 32'h0040001C, t3);
      check("bne_cycles", t3 - t2, 32'd3);

      wait_pc("pc_jr", 32'h00400100, t4);
      check("jal_cycles", t4 - t3, 32'd2);
      read_reg("jal_r31", 5'd31, 32'h00400020);

      wait_pc("pc_ret", 32'h00400020, t5);
      check("jr_cycles", t5 - t4, 32'd3);

      // beq self loop: one fetch every 3 cycles, pc pinned
      f0 = fetches;
      repeat (9) @(negedge clk);
      check("beq_fetches", fetches - f0, 32'd3);
      check("beq_pc", pc, 32'h00400020);

      // Illegal opcode halts on the faulting pc
      rst = 1'b0;
      #1;
      read_reg("rst_r1_clear", 5'd1, 32'h0);
      for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
      imem[0] = 32'h24010001;   // addiu $1,$0,1
      imem[1] = 32'hFC000000;   // opcode 0x3F
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_halt("ill_halted");
      check("ill_pc", pc, 32'h00400004);
      f0 = fetches;
      repeat (10) @(negedge clk);
      check("ill_no_fetch", fetches - f0, 32'd0);
      check("ill_imem_req", {31'b0, imem_req}, 32'h0);
      check("ill_pc_hold", pc, 32'h00400004);
      read_reg("ill_r1", 5'd1, 32'h1);

      // Reset mid-request drops imem_req at once
      rst        = 1'b0;
      imem_ready = 1'b0;
      imem[0]    = 32'h3C1C1000;   // lui $28,0x1000
      imem[1]    = 32'h8F840002;   // lw  $4,2($28)
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("stall_imem_req", {31'b0, imem_req}, 32'h1);
      rst = 1'b0;
      #1;
      check("async_drop_req", {31'b0, imem_req}, 32'h0);

      // Misaligned lw halts without a data request
      @(negedge clk);
      imem_ready = 1'b1;
      rst        = 1'b1;
      d0         = dreqs;
      wait_halt("mis_halted");
      check("mis_pc", pc, 32'h00400004);
      check("mis_no_dreq", dreqs - d0, 32'd0);
      check("mis_dmem_req", {31'b0, dmem_req}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
